// File: rtl/writeback_stage.sv
// Final pipeline stage. It holds the MEM/WB register and waits for the
// data-memory response on loads. It aligns and extends load data, picks the
// writeback source, and drives a single-cycle register-file write strobe.
module writeback_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_rd,
  input  logic [1:0]      mem_wb_sel,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_pc_plus4,
  input  logic [2:0]      mem_funct3,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_reg_write,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_write_data,
  output logic            load_pending,
  output logic [4:0]      load_pending_rd
);

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, WRITE} state_e;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  state_e            state_q;
  logic              reg_write_q;
  logic [4:0]        rd_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lsb_q;
  logic [XLEN-1:0]   data_q;

  logic              accept;
  logic              is_load;
  logic [XLEN-1:0]   sel_d;

  // Align the selected byte/half of a word-aligned read and extend it.
  // Halves only look at address bit 1, so misaligned halves wrap to the
  // enclosing aligned half.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] w,
                                               input logic [2:0]      f3,
                                               input logic [1:0]      lsb);
    logic [XLEN-1:0] sh;
    logic [7:0]      b;
    logic [15:0]     h;
    sh = w >> {lsb, 3'b000};
    b  = sh[7:0];
    h  = lsb[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'h0, b};
      3'b101:  load_ext = {16'h0, h};
      default: load_ext = w;
    endcase
  endfunction

  assign mem_ready = (state_q != WAIT_LOAD);
  assign accept    = mem_valid && mem_ready;
  assign is_load   = (mem_wb_sel == WB_LOAD);

  // Writeback source for non-load instructions; reserved code falls back to ALU.
  always_comb begin
    sel_d = mem_alu_result;
    case (mem_wb_sel)
      WB_PC4:  sel_d = mem_pc_plus4;
      WB_ALU:  sel_d = mem_alu_result;
      default: sel_d = mem_alu_result;
    endcase
  end

  // Control FSM plus the MEM/WB register; a response in WAIT_LOAD blocks
  // any accept that cycle because mem_ready is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      funct3_q    <= 3'd0;
      lsb_q       <= 2'd0;
      data_q      <= '0;
    end else begin
      case (state_q)
        WAIT_LOAD: begin
          if (dmem_rvalid) begin
            data_q  <= load_ext(dmem_rdata, funct3_q, lsb_q);
            state_q <= WRITE;
          end
        end
        default: begin
          if (accept) begin
            reg_write_q <= mem_reg_write;
            rd_q        <= mem_rd;
            funct3_q    <= mem_funct3;
            lsb_q       <= mem_alu_result[1:0];
            if (is_load) begin
              state_q <= WAIT_LOAD;
            end else begin
              data_q  <= sel_d;
              state_q <= WRITE;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign rf_reg_write    = (state_q == WRITE) && reg_write_q && (rd_q != 5'd0);
  assign rf_rd           = rd_q;
  assign rf_write_data   = data_q;
  assign load_pending    = (state_q == WAIT_LOAD);
  assign load_pending_rd = load_pending ? rd_q : 5'd0;

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the RISC-V core and the only writer of the register file's write port. It holds the MEM/WB pipeline register and waits on the data-memory read response for loads. It aligns and sign- or zero-extends load data, selects the writeback source, and drives `rf_reg_write`, `rf_rd` and `rf_write_data` as a single-cycle write strobe. It also exports pending-load status to the hazard unit.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  MEM stage presents an instruction.
- `mem_ready`  out  1  WB accepts it this cycle.
- `mem_reg_write`  in  1  instruction writes `rd`.
- `mem_rd`  in  5  destination register.
- `mem_wb_sel`  in  2  00 ALU result, 01 load data, 10 PC+4, 11 reserved (treated as ALU).
- `mem_alu_result`  in  32  ALU result, also the load address.
- `mem_pc_plus4`  in  32  link value.
- `mem_funct3`  in  3  load type.
- `dmem_rvalid`  in  1  data-memory read response valid.
- `dmem_rdata`  in  32  word-aligned read data.
- `rf_reg_write`  out  1  register-file write enable.
- `rf_rd`  out  5  register-file write address.
- `rf_write_data`  out  32  register-file write data.
- `load_pending`  out  1  a load is waiting for its response.
- `load_pending_rd`  out  5  destination of the pending load (0 when none).

## Operation
- States: IDLE (empty), WAIT_LOAD (load captured, no data yet), WRITE (result valid, strobe cycle).
- `mem_ready` = (state != WAIT_LOAD). It is combinational from state and therefore 1 during reset.
- Accept condition: `mem_valid && mem_ready` at a rising edge. On accept, capture reg_write, rd, wb_sel, funct3, `alu_result[1:0]`, and the result.
- Result on accept:
  - Non-load: the selected value is captured and the next state is WRITE.
  - Load: next state is WAIT_LOAD.
- WAIT_LOAD: when `dmem_rvalid` is sampled high, capture the extended load data and go to WRITE. Otherwise stay.
- WRITE: on accept, go to WRITE (or to WAIT_LOAD for a load). Without accept, go to IDLE.
- IDLE: on accept, take the non-load or load path above. Otherwise stay.
- `dmem_rvalid` outside WAIT_LOAD is ignored and causes no state change.
- `rf_reg_write` = (state == WRITE) && reg_write_q && (rd_q != 0). It is high for exactly one cycle per written instruction.
- `rf_rd` and `rf_write_data` show the held values. They are don't-care when `rf_reg_write` = 0 but must not be X after reset.
- Load extension, with byte select `alu_result[1:0]` and half select `alu_result[1]` (misaligned halves use bit 1 only):
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the selected half.
  - 100 LBU: zero-extend the selected byte.
  - 101 LHU: zero-extend the selected half.
  - 010 and all other codes: full word.
- `load_pending` = (state == WAIT_LOAD). `load_pending_rd` = rd_q in that state, else 0.

## Timing
- Reset (async assert) puts every output and register in its reset state:
  - state = IDLE.
  - `rf_reg_write` = 0, `rf_rd` = 0, `rf_write_data` = 0.
  - `load_pending` = 0, `load_pending_rd` = 0, `mem_ready` = 1.
- Reset deassertion is synchronised externally. The first accept can occur at the first edge after deassertion.
- Non-load latency:
  - Accept at edge N; `rf_reg_write` is high in cycle N..N+1.
  - The register file commits at edge N+1.
  - Back-to-back accepts give one write per cycle.
- Load latency:
  - Accept at edge N; `dmem_rvalid` is seen at edge M > N.
  - `rf_reg_write` is high in cycle M..M+1.
  - `mem_ready` is low from N to M.
- `dmem_rvalid` in the same cycle as the load accept is not sampled for that load; the response must arrive at a later edge.
- Simultaneous response and `mem_valid` in WAIT_LOAD: the response is taken, nothing is accepted, and `mem_ready` rises in the next cycle.
- Accept during WRITE: the register file commits the old values at that edge and the new instruction replaces them in the same edge.
- Reset during WAIT_LOAD: the pending load is discarded with no write. A late `dmem_rvalid` afterwards is ignored.

## Test plan
- ALU op with rd=5, data 0x1234_5678 accepted at edge 1 -> `rf_reg_write`=1 for one cycle with `rf_rd`=5 and data 0x1234_5678; write commits at edge 2.
- rd=0 with reg_write=1, then wb_sel=10 with pc+4=0x104 and rd=1 back-to-back -> no strobe for rd=0; next cycle strobe with rd=1 and data 0x104; `mem_ready` stays 1 throughout.
- LB with addr lsb 11 and rdata 0x80FF_0000, response 3 cycles after accept -> `load_pending`=1 with rd shown and `mem_ready`=0 for 3 cycles, then a strobe with 0xFFFF_FF80; repeat as LBU -> 0x0000_0080; LHU with lsb 10 -> 0x0000_80FF.
- Response arriving together with `mem_valid` -> no accept in that cycle; strobe in the next cycle with the load data; the queued instruction is accepted in the same cycle and strobes one cycle later.
- `rst_n` low mid-WAIT_LOAD, then `dmem_rvalid` pulsed after release -> all outputs return to reset values and no strobe occurs.
- Spurious `dmem_rvalid` in IDLE -> no state change and no strobe.
